param_step_updown_counter: RTL and testbench
============================================

// Module: param_step_updown_counter
// PURPOSE
//   Parametrised step up/down counter: WIDTH-bit count moving by a power-of-two STEP
//   inside a [MIN_VAL, MAX_VAL] window. Selectable clamp or wrap at the window ends.
//   Provides boundary flags and one-cycle event pulses.
//   Generic counting/sequencing block for lab datapaths; drives displays and FSM timing.
// PARAMETERS
//   WIDTH    4    count/data width in bits (2..16)
//   STEP     2    increment/decrement magnitude; must be a power of two, < 2**WIDTH
//   MIN_VAL  0    lower window bound; multiple of STEP
//   MAX_VAL  14   upper window bound; multiple of STEP, MIN_VAL < MAX_VAL <= 2**WIDTH-1
// PORTS
//   clk         in   1      posedge clock
//   reset       in   1      synchronous, active-low reset
//   load        in   1      parallel load enable
//   count_en    in   1      count enable
//   c           in   2      direction: 00=+STEP, 01=-STEP, 10/11=hold
//   wrap_mode   in   1      0=clamp at window end, 1=wrap to opposite end
//   data_in     in   WIDTH  parallel load value (any value)
//   count       out  WIDTH  current count, registered
//   at_min      out  1      count == MIN_VAL (combinational from count)
//   at_max      out  1      count == MAX_VAL (combinational from count)
//   wrap_pulse  out  1      registered; high 1 cycle after an edge where count wrapped
//   limit_pulse out  1      registered; high 1 cycle after a clamped count attempt
// BEHAVIOUR
//   - All state updates on posedge clk. Priority: reset(low) > load > count_en > hold.
//   - Reset: count=MIN_VAL, wrap_pulse=0, limit_pulse=0; so at_min=1, at_max=0.
//     Being synchronous, reset asserted mid-count takes effect at the next posedge.
//     It overrides load/count_en on that edge.
//   - Load normalisation: v = data_in with low log2(STEP) bits cleared.
//     Then v<MIN_VAL -> MIN_VAL; v>MAX_VAL -> MAX_VAL; else v. Pulses = 0 on a load cycle.
//   - Count (count_en=1, load=0): arithmetic in WIDTH+1 bits; no silent modulo-2**WIDTH overflow.
//     c=00, count<MAX_VAL: count+=STEP.
//     c=00, count==MAX_VAL: clamp -> hold, limit_pulse=1; wrap -> count=MIN_VAL, wrap_pulse=1.
//     c=01, count>MIN_VAL: count-=STEP.
//     c=01, count==MIN_VAL: clamp -> hold, limit_pulse=1; wrap -> count=MAX_VAL, wrap_pulse=1.
//     c=10/11: hold, pulses=0.
//   - Pulses deassert on every edge that does not itself generate one.
//     Back-to-back events give continuous high.
//   - count_en=0, load=0: count holds, pulses=0. wrap_mode/c are sampled only on counting edges.
//   - Latency: count and pulses valid 1 cycle after the sampling edge. Flags follow count with 0 delay.
//   - Invariant: after reset/load, count is always a STEP-aligned value within [MIN_VAL, MAX_VAL].
//   - Illegal parameter sets (STEP not pow2, misaligned/unordered bounds) -> $error at elaboration/time 0.
// TESTING (defaults unless stated)
//   1 reset=0 one edge mid-count at count=8 -> count=0, at_min=1, pulses 0; load/en ignored that edge.
//   2 load data_in=4'd13 -> count=12. load 4'd15 with MAX_VAL=10 -> count=10, at_max=1.
//   3 c=00, wrap_mode=0, from 10: 12,14,14; limit_pulse high only after the 3rd edge.
//     Then c=01: count goes to 12 and limit_pulse falls.
//   4 c=00, wrap_mode=1, from 14 -> 0 with wrap_pulse=1 for one cycle.
//     c=01 from 0 -> 14 with wrap_pulse=1.
//   5 WIDTH=8, STEP=4, MIN_VAL=8, MAX_VAL=252, wrap up from 252 -> 8.
//     load 8'd3 -> 8; load 8'd255 -> 252; no 9th-bit overflow.
//   6 load=1 & count_en=1 same edge, data_in=6 -> count=6 (load wins).
//     c=10/11 with en -> hold; random c/en/load/wrap run vs reference model, invariant checked every cycle.

Source files
------------

// File: rtl/param_step_updown_counter.sv
// param_step_updown_counter
// Up/down counter that moves by a power-of-two STEP inside the window
// [MIN_VAL, MAX_VAL]. At a window end the counter either holds (clamp) or
// jumps to the opposite end (wrap). A one-cycle pulse reports each event.
// at_min/at_max are decoded directly from the count register.
module param_step_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int STEP    = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             count_en,
    input  logic [1:0]       c,
    input  logic             wrap_mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count,
    output logic             at_min,
    output logic             at_max,
    output logic             wrap_pulse,
    output logic             limit_pulse
);

    // ------------------------------------------------------------------
    // Parameter legality, reported at elaboration
    // ------------------------------------------------------------------
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("param_step_updown_counter: WIDTH must be in 2..16");
    end
    if (STEP < 1 || (STEP & (STEP - 1)) != 0 || STEP >= (1 << WIDTH)) begin : g_bad_step
        $error("param_step_updown_counter: STEP must be a power of two below 2**WIDTH");
    end
    if (MIN_VAL < 0 || (MIN_VAL % STEP) != 0) begin : g_bad_min
        $error("param_step_updown_counter: MIN_VAL must be a non-negative multiple of STEP");
    end
    if ((MAX_VAL % STEP) != 0) begin : g_bad_max
        $error("param_step_updown_counter: MAX_VAL must be a multiple of STEP");
    end
    if (MIN_VAL >= MAX_VAL || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_order
        $error("param_step_updown_counter: need MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end

    // ------------------------------------------------------------------
    // Constants sized to the datapath
    // ------------------------------------------------------------------
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH:0]   STEP_X     = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_X      = (WIDTH + 1)'(MAX_VAL);
    // Clears the low log2(STEP) bits so any loaded value becomes STEP aligned.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - {{(WIDTH-1){1'b0}}, 1'b1});

    // Align a load value to STEP, then pull it into the window.
    function automatic logic [WIDTH-1:0] normalise_load(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] aligned;
        aligned = value & ALIGN_MASK;
        if (aligned < MIN_W) begin
            normalise_load = MIN_W;
        end else if (aligned > MAX_W) begin
            normalise_load = MAX_W;
        end else begin
            normalise_load = aligned;
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] count_r;
    logic             wrap_pulse_r;
    logic             limit_pulse_r;

    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_nxt_s;
    logic             limit_nxt_s;

    // One extra bit so stepping past either end of the range is visible
    // instead of silently wrapping modulo 2**WIDTH.
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH:0]   down_dif_s;
    logic             up_blocked_s;
    logic             down_blocked_s;

    // Candidate next values for a step in each direction and whether that step leaves the window.
    always_comb begin
        up_sum_s       = {1'b0, count_r} + STEP_X;
        down_dif_s     = {1'b0, count_r} - STEP_X;
        up_blocked_s   = (up_sum_s > MAX_X);
        down_blocked_s = down_dif_s[WIDTH] || (down_dif_s[WIDTH-1:0] < MIN_W);
    end

    // Next-state selection: load beats counting, counting beats hold; pulses default low.
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        limit_nxt_s = 1'b0;
        if (load) begin
            count_nxt_s = normalise_load(data_in);
        end else if (count_en) begin
            case (c)
                2'b00: begin
                    if (!up_blocked_s) begin
                        count_nxt_s = up_sum_s[WIDTH-1:0];
                    end else if (wrap_mode) begin
                        count_nxt_s = MIN_W;
                        wrap_nxt_s  = 1'b1;
                    end else begin
                        limit_nxt_s = 1'b1;
                    end
                end
                2'b01: begin
                    if (!down_blocked_s) begin
                        count_nxt_s = down_dif_s[WIDTH-1:0];
                    end else if (wrap_mode) begin
                        count_nxt_s = MAX_W;
                        wrap_nxt_s  = 1'b1;
                    end else begin
                        limit_nxt_s = 1'b1;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State register with synchronous active-low reset that overrides load and count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r       <= MIN_W;
            wrap_pulse_r  <= 1'b0;
            limit_pulse_r <= 1'b0;
        end else begin
            count_r       <= count_nxt_s;
            wrap_pulse_r  <= wrap_nxt_s;
            limit_pulse_r <= limit_nxt_s;
        end
    end

    assign count       = count_r;
    assign wrap_pulse  = wrap_pulse_r;
    assign limit_pulse = limit_pulse_r;
    assign at_min      = (count_r == MIN_W);
    assign at_max      = (count_r == MAX_W);

endmodule

// File: tb/tb_param_step_updown_counter.sv
// Bench for param_step_updown_counter: three instances (default window,
// narrowed MAX_VAL=10, and an 8-bit STEP=4 window) share the control inputs.
// Expected values come from an integer reference model, are queued when a
// step is driven and are compared after the following clock edge.
module tb_param_step_updown_counter;

    logic       clk;
    logic       reset;
    logic       load;
    logic       count_en;
    logic [1:0] c;
    logic       wrap_mode;
    logic [3:0] din4;
    logic [7:0] din8;

    logic [3:0] count_a, count_b;
    logic [7:0] count_c;
    logic at_min_a, at_max_a, wrap_a, limit_a;
    logic at_min_b, at_max_b, wrap_b, limit_b;
    logic at_min_c, at_max_c, wrap_c, limit_c;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct {
        int ca; int wa; int la;
        int cb; int wb; int lb;
        int cc; int wc; int lc;
    } exp_t;
    exp_t sb[$];

    int ma, mb, mc;

    param_step_updown_counter #(.WIDTH(4), .STEP(2), .MIN_VAL(0), .MAX_VAL(14)) dut_a (
        .clk(clk), .reset(reset), .load(load), .count_en(count_en), .c(c),
        .wrap_mode(wrap_mode), .data_in(din4), .count(count_a), .at_min(at_min_a),
        .at_max(at_max_a), .wrap_pulse(wrap_a), .limit_pulse(limit_a));

    param_step_updown_counter #(.WIDTH(4), .STEP(2), .MIN_VAL(0), .MAX_VAL(10)) dut_b (
        .clk(clk), .reset(reset), .load(load), .count_en(count_en), .c(c),
        .wrap_mode(wrap_mode), .data_in(din4), .count(count_b), .at_min(at_min_b),
        .at_max(at_max_b), .wrap_pulse(wrap_b), .limit_pulse(limit_b));

    param_step_updown_counter #(.WIDTH(8), .STEP(4), .MIN_VAL(8), .MAX_VAL(252)) dut_c (
        .clk(clk), .reset(reset), .load(load), .count_en(count_en), .c(c),
        .wrap_mode(wrap_mode), .data_in(din8), .count(count_c), .at_min(at_min_c),
        .at_max(at_max_c), .wrap_pulse(wrap_c), .limit_pulse(limit_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour, written in plain integer arithmetic.
    task automatic model(input int stp, input int mn, input int mx, input int cur,
                         input logic rst_i, input logic ld, input logic en,
                         input logic [1:0] cc, input logic wm, input int d,
                         output int nxt, output int wp, output int lp);
        int v;
        nxt = cur; wp = 0; lp = 0;
        if (!rst_i) begin
            nxt = mn;
        end else if (ld) begin
            v = d - (d % stp);
            if (v < mn) v = mn;
            if (v > mx) v = mx;
            nxt = v;
        end else if (en) begin
            if (cc == 2'b00) begin
                if (cur + stp > mx) begin
                    if (wm) begin nxt = mn; wp = 1; end
                    else lp = 1;
                end else nxt = cur + stp;
            end else if (cc == 2'b01) begin
                if (cur - stp < mn) begin
                    if (wm) begin nxt = mx; wp = 1; end
                    else lp = 1;
                end else nxt = cur - stp;
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("count_a", count_a, e.ca);
            chk("wrap_a", wrap_a, e.wa);
            chk("limit_a", limit_a, e.la);
            chk("at_min_a", at_min_a, (e.ca == 0) ? 1 : 0);
            chk("at_max_a", at_max_a, (e.ca == 14) ? 1 : 0);
            chk("count_b", count_b, e.cb);
            chk("wrap_b", wrap_b, e.wb);
            chk("limit_b", limit_b, e.lb);
            chk("at_max_b", at_max_b, (e.cb == 10) ? 1 : 0);
            chk("count_c", count_c, e.cc);
            chk("wrap_c", wrap_c, e.wc);
            chk("limit_c", limit_c, e.lc);
            chk("at_min_c", at_min_c, (e.cc == 8) ? 1 : 0);
            chk("at_max_c", at_max_c, (e.cc == 252) ? 1 : 0);
        end
    endtask

    task automatic step(input logic rst_i, input logic ld, input logic en,
                        input logic [1:0] cc, input logic wm,
                        input logic [3:0] d4, input logic [7:0] d8);
        exp_t e;
        @(negedge clk);
        reset = rst_i; load = ld; count_en = en; c = cc; wrap_mode = wm;
        din4 = d4; din8 = d8;
        model(2, 0, 14, ma, rst_i, ld, en, cc, wm, int'(d4), e.ca, e.wa, e.la);
        model(2, 0, 10, mb, rst_i, ld, en, cc, wm, int'(d4), e.cb, e.wb, e.lb);
        model(4, 8, 252, mc, rst_i, ld, en, cc, wm, int'(d8), e.cc, e.wc, e.lc);
        ma = e.ca; mb = e.cb; mc = e.cc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; count_en = 1'b0; c = 2'b00; wrap_mode = 1'b0;
        din4 = 4'd0; din8 = 8'd0;
        ma = 0; mb = 0; mc = 8;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'd0);
        chk("reset_count", count_a, 32'd0);
        chk("reset_at_min", at_min_a, 32'd1);
        chk("reset_at_max", at_max_a, 32'd0);
        chk("reset_count_c", count_c, 32'd8);

        // Load normalisation
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd13, 8'd3);
        chk("load13_a", count_a, 32'd12);
        chk("load13_b", count_b, 32'd10);
        chk("load3_c", count_c, 32'd8);
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd15, 8'd255);
        chk("load15_b", count_b, 32'd10);
        chk("load15_b_atmax", at_max_b, 32'd1);
        chk("load255_c", count_c, 32'd252);

        // Reset mid-count overrides load and count_en
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd6, 8'd100);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 8'd0);
        chk("precount_8", count_a, 32'd8);
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 4'd14, 8'd200);
        chk("midreset_count", count_a, 32'd0);
        chk("midreset_atmin", at_min_a, 32'd1);
        chk("midreset_wrap", wrap_a, 32'd0);
        chk("midreset_limit", limit_a, 32'd0);

        // Clamp up from 10: 12, 14, 14 then down to 12
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd10, 8'd248);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 8'd0);
        chk("clamp_12", count_a, 32'd12);
        chk("clamp_12_lim", limit_a, 32'd0);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 8'd0);
        chk("clamp_14", count_a, 32'd14);
        chk("clamp_14_lim", limit_a, 32'd0);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 8'd0);
        chk("clamp_hold", count_a, 32'd14);
        chk("clamp_hold_lim", limit_a, 32'd1);
        step(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 4'd0, 8'd0);
        chk("clamp_down", count_a, 32'd12);
        chk("clamp_down_lim", limit_a, 32'd0);

        // Wrap up 14 -> 0, then wrap down 0 -> 14
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 4'd14, 8'd252);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 4'd0, 8'd0);
        chk("wrap_up", count_a, 32'd0);
        chk("wrap_up_pulse", wrap_a, 32'd1);
        chk("wrap_up_c", count_c, 32'd8);
        chk("wrap_up_c_pulse", wrap_c, 32'd1);
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 8'd0);
        chk("wrap_pulse_fall", wrap_a, 32'd0);
        step(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 4'd0, 8'd0);
        chk("wrap_down", count_a, 32'd14);
        chk("wrap_down_pulse", wrap_a, 32'd1);

        // Load wins over count; c=10/11 hold
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 4'd6, 8'd64);
        chk("load_wins", count_a, 32'd6);
        step(1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 4'd0, 8'd0);
        chk("hold_10", count_a, 32'd6);
        step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 4'd0, 8'd0);
        chk("hold_11", count_a, 32'd6);

        // Random run against the model, with the window invariant every cycle
        for (int i = 0; i < 400; i++) begin
            logic r_rst, r_ld, r_en, r_wm;
            logic [1:0] r_c;
            r_rst = ($urandom_range(0, 40) != 0);
            r_ld  = ($urandom_range(0, 5) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_wm  = 1'($urandom_range(0, 1));
            r_c   = 2'($urandom_range(0, 3));
            step(r_rst, r_ld, r_en, r_c, r_wm, 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)));
            chk("inv_a", (count_a[0] == 1'b0 && count_a <= 4'd14) ? 32'd1 : 32'd0, 32'd1);
            chk("inv_b", (count_b[0] == 1'b0 && count_b <= 4'd10) ? 32'd1 : 32'd0, 32'd1);
            chk("inv_c", (count_c[1:0] == 2'b00 && count_c >= 8'd8 && count_c <= 8'd252)
                         ? 32'd1 : 32'd0, 32'd1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
